ray_recirculator: RTL and testbench

RAY_RECIRCULATOR -- requirements
Module: ray_recirculator

---
 rtl/ray_recirculator_pkg.sv | 20 ++
 rtl/ray_entry_fifo.sv | 36 +++
 rtl/ray_recirculator.sv | 98 +++++++++
 tb/tb_ray_recirculator.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ray_recirculator_pkg.sv
// ray_recirculator_pkg: fp types and the recirculation entry shared by the recirculator and its FIFO.
package ray_recirculator_pkg;
  localparam int FP_BITS = 32;
  localparam int FP_VEC3_BITS = 3 * FP_BITS;
  localparam logic [FP_BITS-1:0] FP_ONE = 32'h3f80_0000;
  localparam int RECIRC_PIXEL_BITS = 16;
  localparam int RECIRC_BOUNCE_BITS = 4;
  typedef logic [FP_BITS-1:0] fp_t;
  typedef struct packed {fp_t x, y, z;} fp_vec3;
  typedef struct packed {fp_t r, g, b;} fp_color;
  typedef struct packed {
    fp_vec3 dir;
    fp_vec3 origin;
    fp_color color;
    fp_color light;
    logic [RECIRC_PIXEL_BITS-1:0] pixel;
    logic [RECIRC_BOUNCE_BITS-1:0] bounces;
    logic retire;
  } recirc_entry_t;
endpackage

// File: rtl/ray_entry_fifo.sv
// ray_entry_fifo: single-clock FIFO of recirculation entries with occupancy count.
module ray_entry_fifo
  import ray_recirculator_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  recirc_entry_t wr_data,
  input  logic          rd_en,
  output recirc_entry_t rd_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  recirc_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr_en) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1);
      if (rd_en) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end
  always_ff @(posedge clk) if (wr_en) mem[wp] <= wr_data;
  assign rd_data = mem[rp];
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
endmodule

// File: rtl/ray_recirculator.sv
// ray_recirculator: merges primaries and reflected rays into an in-order relaunch/retire stream under a credit pool.
module ray_recirculator
  import ray_recirculator_pkg::*;
#(
  parameter int MAX_BOUNCES = 4,
  parameter int DEPTH = 16,
  parameter int PIXEL_BITS = 16,
  parameter int BOUNCE_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prim_valid,
  output logic                    prim_ready,
  input  logic [FP_VEC3_BITS-1:0] prim_dir,
  input  logic [FP_VEC3_BITS-1:0] prim_origin,
  input  logic [PIXEL_BITS-1:0]   prim_pixel,
  input  logic                    refl_valid,
  input  logic [FP_VEC3_BITS-1:0] refl_dir,
  input  logic [FP_VEC3_BITS-1:0] refl_origin,
  input  logic [FP_VEC3_BITS-1:0] refl_color,
  input  logic [FP_VEC3_BITS-1:0] refl_light,
  input  logic [PIXEL_BITS-1:0]   refl_pixel,
  input  logic [BOUNCE_BITS-1:0]  refl_bounces,
  output logic                    ray_valid,
  input  logic                    ray_ready,
  output logic [FP_VEC3_BITS-1:0] ray_dir,
  output logic [FP_VEC3_BITS-1:0] ray_origin,
  output logic [FP_VEC3_BITS-1:0] ray_color,
  output logic [FP_VEC3_BITS-1:0] ray_light,
  output logic [PIXEL_BITS-1:0]   ray_pixel,
  output logic [BOUNCE_BITS-1:0]  ray_bounces,
  output logic                    ret_valid,
  input  logic                    ret_ready,
  output logic [FP_VEC3_BITS-1:0] ret_light,
  output logic [PIXEL_BITS-1:0]   ret_pixel,
  output logic [BOUNCE_BITS-1:0]  ret_bounces,
  output logic                    overflow
);
  localparam int CW = $clog2(DEPTH + 1);
  recirc_entry_t wr_data, head;
  logic [CW-1:0] count, inflight;
  logic [BOUNCE_BITS-1:0] next_b;
  logic empty, full, wr_ok, pop, launch, head_relaunch, load_ok, relaunch_load, prim_fire;
  always_comb begin
    next_b = refl_bounces + BOUNCE_BITS'(1);
    wr_data.dir = refl_dir;
    wr_data.origin = refl_origin;
    wr_data.color = refl_color;
    wr_data.light = refl_light;
    wr_data.pixel = RECIRC_PIXEL_BITS'(refl_pixel);
    wr_data.bounces = RECIRC_BOUNCE_BITS'(next_b);
    wr_data.retire = next_b == BOUNCE_BITS'(MAX_BOUNCES) || refl_color == '0;
    head_relaunch = !empty && !head.retire;
    ret_valid = rst && !empty && head.retire;
    load_ok = !ray_valid || ray_ready;
    relaunch_load = head_relaunch && load_ok;
    // Credits cover both queued entries and rays still out at the intersector.
    prim_ready = rst && !head_relaunch && (int'(count) + int'(inflight) < DEPTH) && load_ok;
    prim_fire = prim_valid && prim_ready;
    launch = ray_valid && ray_ready;
    wr_ok = refl_valid && inflight != '0 && !full;
    pop = (ret_valid && ret_ready) || relaunch_load;
    ret_light = ret_valid ? head.light : '0;
    ret_pixel = ret_valid ? PIXEL_BITS'(head.pixel) : '0;
    ret_bounces = ret_valid ? BOUNCE_BITS'(head.bounces) : '0;
  end
  ray_entry_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clk), .rst(rst), .wr_en(wr_ok), .wr_data(wr_data), .rd_en(pop),
    .rd_data(head), .count(count), .empty(empty), .full(full)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight <= '0;
      overflow <= 1'b0;
      ray_valid <= 1'b0;
      ray_dir <= '0;
      ray_origin <= '0;
      ray_color <= '0;
      ray_light <= '0;
      ray_pixel <= '0;
      ray_bounces <= '0;
    end else begin
      inflight <= inflight + CW'(launch) - CW'(wr_ok);
      overflow <= overflow || (refl_valid && !wr_ok);
      if (relaunch_load || prim_fire) begin
        ray_valid <= 1'b1;
        ray_dir <= relaunch_load ? head.dir : prim_dir;
        ray_origin <= relaunch_load ? head.origin : prim_origin;
        ray_color <= relaunch_load ? head.color : {FP_ONE, FP_ONE, FP_ONE};
        ray_light <= relaunch_load ? head.light : '0;
        ray_pixel <= relaunch_load ? PIXEL_BITS'(head.pixel) : prim_pixel;
        ray_bounces <= relaunch_load ? BOUNCE_BITS'(head.bounces) : '0;
      end else if (ray_ready) begin
        ray_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ray_recirculator.sv
// tb_ray_recirculator: directed checks of launch, recirculation, retire, credits and overflow.
module tb_ray_recirculator;
  import ray_recirculator_pkg::*;
  localparam logic [FP_VEC3_BITS-1:0] ONE3 = {FP_ONE, FP_ONE, FP_ONE};
  localparam logic [FP_VEC3_BITS-1:0] COL = {32'h3f00_0000, 32'h3e80_0000, 32'h3f40_0000};
  localparam logic [FP_VEC3_BITS-1:0] LIT = {32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
  localparam logic [FP_VEC3_BITS-1:0] DIR = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
  logic clk = 0, rst = 0;
  logic prim_valid = 0, prim_ready, refl_valid = 0, ray_valid, ray_ready = 1, ret_valid, ret_ready = 1, overflow;
  logic [FP_VEC3_BITS-1:0] prim_dir = '0, prim_origin = '0, refl_dir = '0, refl_origin = '0, refl_color = '0, refl_light = '0;
  logic [FP_VEC3_BITS-1:0] ray_dir, ray_origin, ray_color, ray_light, ret_light;
  logic [15:0] prim_pixel = '0, refl_pixel = '0, ray_pixel, ret_pixel;
  logic [3:0] refl_bounces = '0, ray_bounces, ret_bounces;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ray_recirculator #(.MAX_BOUNCES(4), .DEPTH(4), .PIXEL_BITS(16), .BOUNCE_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .prim_valid(prim_valid), .prim_ready(prim_ready), .prim_dir(prim_dir), .prim_origin(prim_origin), .prim_pixel(prim_pixel),
    .refl_valid(refl_valid), .refl_dir(refl_dir), .refl_origin(refl_origin), .refl_color(refl_color), .refl_light(refl_light),
    .refl_pixel(refl_pixel), .refl_bounces(refl_bounces),
    .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_dir(ray_dir), .ray_origin(ray_origin), .ray_color(ray_color),
    .ray_light(ray_light), .ray_pixel(ray_pixel), .ray_bounces(ray_bounces),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_light(ret_light), .ret_pixel(ret_pixel), .ret_bounces(ret_bounces),
    .overflow(overflow)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic refl(input logic [15:0] pix, input logic [3:0] b, input logic [FP_VEC3_BITS-1:0] col);
    refl_valid = 1;
    refl_pixel = pix;
    refl_bounces = b;
    refl_color = col;
    refl_light = LIT;
    refl_dir = DIR;
    tick();
    refl_valid = 0;
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_ray_valid", ray_valid, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_prim_ready", prim_ready, 0);
    chk("rst_ray_pixel", ray_pixel, 0);
    chk("rst_ray_color", ray_color, 0);
    chk("rst_ret_pixel", ret_pixel, 0);
    rst = 1;
    tick();
    chk("rel_prim_ready", prim_ready, 1);
    prim_valid = 1; prim_pixel = 7; prim_dir = DIR; prim_origin = LIT;
    tick();
    prim_valid = 0;
    chk("p7_valid", ray_valid, 1);
    chk("p7_pixel", ray_pixel, 7);
    chk("p7_bounces", ray_bounces, 0);
    chk("p7_color", ray_color, ONE3);
    chk("p7_light", ray_light, 0);
    chk("p7_dir", ray_dir, DIR);
    chk("p7_origin", ray_origin, LIT);
    tick();
    chk("p7_fired", ray_valid, 0);
    for (int b = 0; b < 3; b++) begin
      refl(7, 4'(b), COL);
      chk("bnc_no_ret", ret_valid, 0);
      chk("bnc_prim_blocked", prim_ready, 0);
      tick();
      chk("bnc_valid", ray_valid, 1);
      chk("bnc_bounces", ray_bounces, 128'(b + 1));
      chk("bnc_pixel", ray_pixel, 7);
      chk("bnc_color", ray_color, COL);
      chk("bnc_light", ray_light, LIT);
      tick();
      chk("bnc_fired", ray_valid, 0);
    end
    refl(7, 3, COL);
    chk("max_ret_valid", ret_valid, 1);
    chk("max_ret_pixel", ret_pixel, 7);
    chk("max_ret_bounces", ret_bounces, 4);
    chk("max_ret_light", ret_light, LIT);
    chk("max_no_ray", ray_valid, 0);
    tick();
    chk("max_popped", ret_valid, 0);
    prim_valid = 1; prim_pixel = 9;
    tick();
    prim_valid = 0;
    tick();
    refl(9, 1, '0);
    chk("blk_ret_valid", ret_valid, 1);
    chk("blk_ret_bounces", ret_bounces, 2);
    chk("blk_ret_pixel", ret_pixel, 9);
    tick();
    chk("blk_popped", ret_valid, 0);
    chk("blk_no_ray", ray_valid, 0);
    prim_valid = 1; prim_pixel = 10;
    tick();
    prim_pixel = 11;
    tick();
    prim_valid = 0;
    tick();
    chk("two_fired", ray_valid, 0);
    ret_ready = 0;
    refl(10, 3, COL);
    refl(11, 0, COL);
    chk("ord_ret_valid", ret_valid, 1);
    chk("ord_ret_pixel", ret_pixel, 10);
    chk("ord_no_ray", ray_valid, 0);
    tick();
    chk("ord_hold_valid", ret_valid, 1);
    chk("ord_hold_pixel", ret_pixel, 10);
    chk("ord_hold_bounces", ret_bounces, 4);
    chk("ord_hold_no_ray", ray_valid, 0);
    ret_ready = 1;
    tick();
    chk("ord_popped", ret_valid, 0);
    tick();
    chk("ord_relaunch_valid", ray_valid, 1);
    chk("ord_relaunch_pixel", ray_pixel, 11);
    chk("ord_relaunch_bounces", ray_bounces, 1);
    tick();
    refl(11, 3, COL);
    tick();
    chk("drain_empty", ret_valid, 0);
    prim_valid = 1; prim_pixel = 20;
    repeat (4) tick();
    prim_valid = 0;
    tick();
    chk("cred_exhausted", prim_ready, 0);
    chk("cred_no_ray", ray_valid, 0);
    refl(20, 3, COL);
    chk("cred_ret_valid", ret_valid, 1);
    chk("cred_still_full", prim_ready, 0);
    tick();
    chk("cred_returned", prim_ready, 1);
    rst = 0;
    repeat (2) tick();
    rst = 1;
    tick();
    chk("mid_rst_ray", ray_valid, 0);
    chk("mid_rst_ret", ret_valid, 0);
    chk("mid_rst_prim_ready", prim_ready, 1);
    refl(5, 3, COL);
    chk("ovf_set", overflow, 1);
    chk("ovf_dropped", ret_valid, 0);
    chk("ovf_count_same", prim_ready, 1);
    ray_ready = 0;
    prim_valid = 1; prim_pixel = 33;
    tick();
    prim_valid = 0;
    chk("hold_valid", ray_valid, 1);
    chk("hold_pixel", ray_pixel, 33);
    chk("hold_prim_blocked", prim_ready, 0);
    tick();
    chk("hold2_valid", ray_valid, 1);
    chk("hold2_pixel", ray_pixel, 33);
    chk("hold2_color", ray_color, ONE3);
    chk("ovf_sticky", overflow, 1);
    ray_ready = 1;
    tick();
    chk("hold_released", ray_valid, 0);
    rst = 0;
    tick();
    chk("ovf_cleared", overflow, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
